// File: rtl/ycr1_tcm_access_ctrl_if.sv
// ----------------------------------------------------------------------------
// ycr1_tcm_access_ctrl_if
// Core-side request/response bundle for the TCM access controller.
//   imem_*: fetch request (req, addr) and response (req_ack, rdata, resp)
//   dmem_*: data request (req, cmd, width, addr, wdata) and response
//           (req_ack, rdata, resp)
// Modports:
//   master - the core (drives requests, receives responses)
//   slave  - the access controller
// resp encoding: 00 idle, 01 ok, 10 error.
// ----------------------------------------------------------------------------
interface ycr1_tcm_access_ctrl_if #(
    parameter int AW = 16
) ();
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_req_ack;
    logic [31:0]   imem_rdata;
    logic [1:0]    imem_resp;

    logic          dmem_req;
    logic          dmem_cmd;
    logic [1:0]    dmem_width;
    logic [AW-1:0] dmem_addr;
    logic [31:0]   dmem_wdata;
    logic          dmem_req_ack;
    logic [31:0]   dmem_rdata;
    logic [1:0]    dmem_resp;

    modport master (
        output imem_req, imem_addr,
        input  imem_req_ack, imem_rdata, imem_resp,
        output dmem_req, dmem_cmd, dmem_width, dmem_addr, dmem_wdata,
        input  dmem_req_ack, dmem_rdata, dmem_resp
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_req_ack, imem_rdata, imem_resp,
        input  dmem_req, dmem_cmd, dmem_width, dmem_addr, dmem_wdata,
        output dmem_req_ack, dmem_rdata, dmem_resp
    );
endinterface

// File: rtl/ycr1_tcm_access_ctrl.sv
// ----------------------------------------------------------------------------
// ycr1_tcm_access_ctrl
// Front-end of the dual-port TCM. Turns core fetch requests into port A
// reads and core data requests into port B reads/writes, checks alignment,
// steers sub-word store/load byte lanes and sequences responses against the
// memory's 1-cycle read latency.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   core (slave)      imem_*/dmem_* request/response bundle
//   mem_rena/addra    port A read enable / word address
//   mem_qa            port A read data (1 cycle after mem_rena)
//   mem_renb/wenb     port B read / write enable
//   mem_webb          port B byte enables
//   mem_addrb/datab   port B word address / write data
//   mem_qb            port B read data (1 cycle after mem_renb)
//
// Optional build macro: YCR1_TCM_RESP_REG_EN
//   defined   - extra register stage on resp/rdata of both ports (latency 2)
//   undefined - latency 1, rdata steered combinationally from mem_qa/mem_qb
// ----------------------------------------------------------------------------
module ycr1_tcm_access_ctrl #(
    parameter int          YCR1_WIDTH = 32,
    parameter logic [31:0] YCR1_SIZE  = 32'h00010000,
    localparam int         AW         = $clog2(YCR1_SIZE)
) (
    input  logic                  clk,
    input  logic                  rst,
    ycr1_tcm_access_ctrl_if.slave core,

    output logic                  mem_rena,
    output logic [AW-3:0]         mem_addra,
    input  logic [YCR1_WIDTH-1:0] mem_qa,

    output logic                  mem_renb,
    output logic                  mem_wenb,
    output logic [3:0]            mem_webb,
    output logic [AW-3:0]         mem_addrb,
    output logic [YCR1_WIDTH-1:0] mem_datab,
    input  logic [YCR1_WIDTH-1:0] mem_qb
);

    localparam logic [1:0] W_BYTE = 2'b00;
    localparam logic [1:0] W_HALF = 2'b01;
    localparam logic [1:0] W_WORD = 2'b10;

    localparam logic [1:0] RESP_IDLE = 2'b00;
    localparam logic [1:0] RESP_OK   = 2'b01;
    localparam logic [1:0] RESP_ERR  = 2'b10;

    // Data-port response pipeline entry: what is needed one cycle later to
    // shape the load result.
    typedef struct packed {
        logic       vld;
        logic       err;
        logic       wr;
        logic [1:0] off;
        logic [1:0] width;
    } dpipe_t;

    logic   i_vld_q, i_vld_d;
    logic   i_err_q, i_err_d;
    dpipe_t d_q, d_d;

    logic       i_err;
    logic       d_err;
    logic       d_acc;
    logic [1:0] d_off;

    logic [1:0]            i_resp_s1, d_resp_s1;
    logic [YCR1_WIDTH-1:0] i_rdata_s1, d_rdata_s1;
    logic [YCR1_WIDTH-1:0] d_shift;

    // No backpressure: everything is accepted outside reset.
    assign core.imem_req_ack = !rst;
    assign core.dmem_req_ack = !rst;

    // ------------------------------------------------------------------
    // Fetch port (A)
    // ------------------------------------------------------------------
    assign i_err     = (core.imem_addr[1:0] != 2'b00);
    assign mem_rena  = !rst && core.imem_req && !i_err;
    assign mem_addra = core.imem_addr[AW-1:2];

    assign i_vld_d = core.imem_req;
    assign i_err_d = i_err;

    // ------------------------------------------------------------------
    // Data port (B)
    // ------------------------------------------------------------------
    assign d_off     = core.dmem_addr[1:0];
    assign d_acc     = !rst && core.dmem_req;
    assign mem_addrb = core.dmem_addr[AW-1:2];

    always_comb begin
        d_err = 1'b0;
        case (core.dmem_width)
            W_BYTE:  d_err = 1'b0;
            W_HALF:  d_err = d_off[0];
            W_WORD:  d_err = (d_off != 2'b00);
            default: d_err = 1'b1;
        endcase
    end

    assign mem_renb = d_acc && !d_err && !core.dmem_cmd;
    assign mem_wenb = d_acc && !d_err &&  core.dmem_cmd;

    // Store lane steering: replicate the LSB-aligned data into every lane
    // and let the byte enables pick the target lane(s).
    always_comb begin
        mem_webb  = 4'b0000;
        mem_datab = core.dmem_wdata;
        case (core.dmem_width)
            W_BYTE: begin
                mem_webb  = 4'b0001 << d_off;
                mem_datab = {4{core.dmem_wdata[7:0]}};
            end
            W_HALF: begin
                mem_webb  = 4'b0011 << d_off;
                mem_datab = {2{core.dmem_wdata[15:0]}};
            end
            default: begin
                mem_webb  = 4'b1111;
                mem_datab = core.dmem_wdata;
            end
        endcase
        if (!mem_wenb) begin
            mem_webb = 4'b0000;
        end
    end

    always_comb begin
        d_d       = '0;
        d_d.vld   = core.dmem_req;
        d_d.err   = d_err;
        d_d.wr    = core.dmem_cmd;
        d_d.off   = d_off;
        d_d.width = core.dmem_width;
    end

    // ------------------------------------------------------------------
    // Response pipeline stage 1 (aligned with the memory read latency)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_vld_q <= 1'b0;
            i_err_q <= 1'b0;
            d_q     <= '0;
        end else begin
            i_vld_q <= i_vld_d;
            i_err_q <= i_err_d;
            d_q     <= d_d;
        end
    end

    always_comb begin
        i_resp_s1  = RESP_IDLE;
        i_rdata_s1 = '0;
        if (i_vld_q) begin
            i_resp_s1 = i_err_q ? RESP_ERR : RESP_OK;
            if (!i_err_q) begin
                i_rdata_s1 = mem_qa;
            end
        end
    end

    // Load result: bring the addressed lane down to bit 0, then zero-extend.
    assign d_shift = mem_qb >> {d_q.off, 3'b000};

    always_comb begin
        d_resp_s1  = RESP_IDLE;
        d_rdata_s1 = '0;
        if (d_q.vld) begin
            d_resp_s1 = d_q.err ? RESP_ERR : RESP_OK;
            if (!d_q.err && !d_q.wr) begin
                case (d_q.width)
                    W_BYTE:  d_rdata_s1 = {24'h0, d_shift[7:0]};
                    W_HALF:  d_rdata_s1 = {16'h0, d_shift[15:0]};
                    default: d_rdata_s1 = d_shift;
                endcase
            end
        end
    end

`ifdef YCR1_TCM_RESP_REG_EN
    // ------------------------------------------------------------------
    // Optional stage 2: registers resp/rdata, one more cycle of latency
    // ------------------------------------------------------------------
    logic [1:0]            i_resp_q,  d_resp_q;
    logic [YCR1_WIDTH-1:0] i_rdata_q, d_rdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_resp_q  <= RESP_IDLE;
            i_rdata_q <= '0;
            d_resp_q  <= RESP_IDLE;
            d_rdata_q <= '0;
        end else begin
            i_resp_q  <= i_resp_s1;
            i_rdata_q <= i_rdata_s1;
            d_resp_q  <= d_resp_s1;
            d_rdata_q <= d_rdata_s1;
        end
    end

    assign core.imem_resp  = i_resp_q;
    assign core.imem_rdata = i_rdata_q;
    assign core.dmem_resp  = d_resp_q;
    assign core.dmem_rdata = d_rdata_q;
`else
    assign core.imem_resp  = i_resp_s1;
    assign core.imem_rdata = i_rdata_s1;
    assign core.dmem_resp  = d_resp_s1;
    assign core.dmem_rdata = d_rdata_s1;
`endif

endmodule

// File: tb/tb_ycr1_tcm_access_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ycr1_tcm_access_ctrl
// Directed bench for ycr1_tcm_access_ctrl with a behavioural dual-port TCM
// (1-cycle read latency, byte-enabled writes on port B). Expected latency
// follows YCR1_TCM_RESP_REG_EN.
// ----------------------------------------------------------------------------
module tb_ycr1_tcm_access_ctrl;

`ifdef YCR1_TCM_RESP_REG_EN
    localparam int L = 2;
`else
    localparam int L = 1;
`endif

    localparam int AW = 16;

    logic clk;
    logic rst;

    logic          mem_rena;
    logic [AW-3:0] mem_addra;
    logic [31:0]   mem_qa;
    logic          mem_renb;
    logic          mem_wenb;
    logic [3:0]    mem_webb;
    logic [AW-3:0] mem_addrb;
    logic [31:0]   mem_datab;
    logic [31:0]   mem_qb;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] tmem [0:16383];

    ycr1_tcm_access_ctrl_if #(.AW(AW)) core_if ();

    ycr1_tcm_access_ctrl #(
        .YCR1_WIDTH (32),
        .YCR1_SIZE  (32'h00010000)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .core      (core_if),
        .mem_rena  (mem_rena),
        .mem_addra (mem_addra),
        .mem_qa    (mem_qa),
        .mem_renb  (mem_renb),
        .mem_wenb  (mem_wenb),
        .mem_webb  (mem_webb),
        .mem_addrb (mem_addrb),
        .mem_datab (mem_datab),
        .mem_qb    (mem_qb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural TCM; preloaded while reset is held.
    always @(posedge clk) begin
        if (rst) begin
            tmem[4]     <= 32'hDEADBEEF;
            tmem[16'h40] <= 32'h11221234;
            tmem[16'h81] <= 32'h00000000;
            for (int j = 0; j < 8; j++) tmem[16'h100 + j] <= 32'h5A5A0000 + j;
        end else begin
            if (mem_rena) mem_qa <= tmem[mem_addra];
            if (mem_renb) mem_qb <= tmem[mem_addrb];
            if (mem_wenb)
                for (int b = 0; b < 4; b++)
                    if (mem_webb[b]) tmem[mem_addrb][8*b +: 8] <= mem_datab[8*b +: 8];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_all();
        core_if.imem_req   = 1'b0;
        core_if.imem_addr  = '0;
        core_if.dmem_req   = 1'b0;
        core_if.dmem_cmd   = 1'b0;
        core_if.dmem_width = 2'b00;
        core_if.dmem_addr  = '0;
        core_if.dmem_wdata = '0;
    endtask

    task automatic drv_i(input logic [15:0] a);
        core_if.imem_req  = 1'b1;
        core_if.imem_addr = a;
    endtask

    task automatic drv_d(input logic cmd, input logic [1:0] w, input logic [15:0] a,
                         input logic [31:0] wd);
        core_if.dmem_req   = 1'b1;
        core_if.dmem_cmd   = cmd;
        core_if.dmem_width = w;
        core_if.dmem_addr  = a;
        core_if.dmem_wdata = wd;
    endtask

    // Accept current request at the next edge, drop requests, then advance so
    // the response of that request is visible.
    task automatic to_resp();
        @(posedge clk); #1;
        idle_all();
        for (int k = 1; k < L; k++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic chk_derr(input string tag);
        chk({tag, "_renb"}, {31'b0, mem_renb}, 32'd0);
        chk({tag, "_wenb"}, {31'b0, mem_wenb}, 32'd0);
        chk({tag, "_webb"}, {28'b0, mem_webb}, 32'd0);
        to_resp();
        chk({tag, "_resp"},  {30'b0, core_if.dmem_resp}, 32'd2);
        chk({tag, "_rdata"}, core_if.dmem_rdata, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        idle_all();
        #3;
        chk("rst_imem_resp",  {30'b0, core_if.imem_resp}, 32'd0);
        chk("rst_dmem_resp",  {30'b0, core_if.dmem_resp}, 32'd0);
        chk("rst_imem_rdata", core_if.imem_rdata, 32'd0);
        chk("rst_dmem_rdata", core_if.dmem_rdata, 32'd0);
        chk("rst_iack",       {31'b0, core_if.imem_req_ack}, 32'd0);
        chk("rst_dack",       {31'b0, core_if.dmem_req_ack}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("ack_after_rst",  {30'b0, core_if.imem_req_ack, core_if.dmem_req_ack}, 32'd3);

        // Aligned word fetch
        drv_i(16'h0010);
        #1;
        chk("fetch_rena",  {31'b0, mem_rena}, 32'd1);
        chk("fetch_addra", {18'b0, mem_addra}, 32'h004);
        to_resp();
        chk("fetch_resp",  {30'b0, core_if.imem_resp}, 32'd1);
        chk("fetch_rdata", core_if.imem_rdata, 32'hDEADBEEF);
        @(posedge clk); #1;
        chk("fetch_idle",  {30'b0, core_if.imem_resp}, 32'd0);

        // Byte store 0xA5 to 0x0103
        drv_d(1'b1, 2'b00, 16'h0103, 32'h000000A5);
        #1;
        chk("sb_wenb",  {31'b0, mem_wenb}, 32'd1);
        chk("sb_renb",  {31'b0, mem_renb}, 32'd0);
        chk("sb_webb",  {28'b0, mem_webb}, 32'b1000);
        chk("sb_datab", mem_datab, 32'hA5A5A5A5);
        chk("sb_addrb", {18'b0, mem_addrb}, 32'h040);
        to_resp();
        chk("sb_resp",  {30'b0, core_if.dmem_resp}, 32'd1);
        chk("sb_rdata", core_if.dmem_rdata, 32'd0);

        // Half load at 0x0102: word is now 0xA5221234
        drv_d(1'b0, 2'b01, 16'h0102, 32'h0);
        #1;
        chk("lh_renb", {31'b0, mem_renb}, 32'd1);
        to_resp();
        chk("lh_resp",  {30'b0, core_if.dmem_resp}, 32'd1);
        chk("lh_rdata", core_if.dmem_rdata, 32'h0000A522);

        // Byte load at 0x0101 -> 0x12
        drv_d(1'b0, 2'b00, 16'h0101, 32'h0);
        to_resp();
        chk("lb_rdata", core_if.dmem_rdata, 32'h00000012);

        // Half store 0xBEEF to 0x0206, read back as a word
        drv_d(1'b1, 2'b01, 16'h0206, 32'h1234BEEF);
        #1;
        chk("sh_webb",  {28'b0, mem_webb}, 32'b1100);
        chk("sh_datab", mem_datab, 32'hBEEFBEEF);
        to_resp();
        drv_d(1'b0, 2'b10, 16'h0204, 32'h0);
        to_resp();
        chk("lw_rdata", core_if.dmem_rdata, 32'hBEEF0000);

        // Alignment errors
        drv_d(1'b0, 2'b01, 16'h0001, 32'h0);
        #1;
        chk_derr("err_half");
        drv_d(1'b1, 2'b10, 16'h0002, 32'hFFFFFFFF);
        #1;
        chk_derr("err_word");
        drv_d(1'b1, 2'b11, 16'h0000, 32'hFFFFFFFF);
        #1;
        chk_derr("err_w11");

        // Misaligned fetch; mem_qa still holds stale data that must not leak
        drv_i(16'h0006);
        #1;
        chk("ferr_rena", {31'b0, mem_rena}, 32'd0);
        to_resp();
        chk("ferr_resp",  {30'b0, core_if.imem_resp}, 32'd2);
        chk("ferr_rdata", core_if.imem_rdata, 32'd0);

        // Streaming: 8 fetches + 8 alternating word store/load, back to back
        for (int c = 0; c < 8 + L; c++) begin
            if (c >= L) begin
                int j;
                j = c - L;
                chk("strm_iresp",  {30'b0, core_if.imem_resp}, 32'd1);
                chk("strm_irdata", core_if.imem_rdata, 32'h5A5A0000 + j);
                chk("strm_dresp",  {30'b0, core_if.dmem_resp}, 32'd1);
                chk("strm_drdata", core_if.dmem_rdata,
                    (j % 2 == 0) ? 32'd0 : (32'hC0DE0000 + j / 2));
            end
            if (c < 8) begin
                drv_i(16'h0400 + 16'(4 * c));
                if (c % 2 == 0) drv_d(1'b1, 2'b10, 16'h0800 + 16'(2 * c), 32'hC0DE0000 + c / 2);
                else            drv_d(1'b0, 2'b10, 16'h0800 + 16'(2 * (c - 1)), 32'h0);
            end else begin
                idle_all();
            end
            @(posedge clk); #1;
        end
        chk("strm_end_i", {30'b0, core_if.imem_resp}, 32'd0);
        chk("strm_end_d", {30'b0, core_if.dmem_resp}, 32'd0);

        // Reset right after a load is accepted: its response is discarded
        drv_d(1'b0, 2'b10, 16'h0010, 32'h0);
        drv_i(16'h0010);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("mrst_dresp", {30'b0, core_if.dmem_resp}, 32'd0);
        chk("mrst_ack",   {30'b0, core_if.imem_req_ack, core_if.dmem_req_ack}, 32'd0);
        chk("mrst_strb",  {25'b0, mem_rena, mem_renb, mem_wenb, mem_webb}, 32'd0);
        chk("mrst_rdata", core_if.dmem_rdata, 32'd0);
        @(posedge clk); #1;
        chk("mrst_dresp2", {30'b0, core_if.dmem_resp}, 32'd0);
        @(negedge clk);
        idle_all();
        rst = 1'b0;
        for (int k = 0; k <= L; k++) begin
            @(posedge clk); #1;
            chk("post_rst_dresp", {30'b0, core_if.dmem_resp}, 32'd0);
            chk("post_rst_iresp", {30'b0, core_if.imem_resp}, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Hard time limit so the run always terminates.
    initial begin
        #100000;
        $display("FAIL timeout: observed no end, required finish before 100000");
        $fatal(1, "timeout");
    end

endmodule
